// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states,
// default widths, iteration counts and divide-by-zero result constants.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

  // One quotient bit per cycle, or two when the radix-4 path is built.
  localparam int ITER_R2 = DW_DEF;
  localparam int ITER_R4 = DW_DEF / 2;
  localparam int CNT_W   = $clog2(ITER_R2) + 1;

  localparam logic [DW_DEF-1:0] DZ_QUOT = {DW_DEF{1'b1}};
  localparam logic [VW_DEF-1:0] DZ_REM  = {VW_DEF{1'b0}};

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend
// bit, trial-subtract the divisor magnitude, keep the difference if it
// did not borrow.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   rem_in,
  input  logic          dvd_bit,
  input  logic [VW-1:0] dvs_mag,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] diff;

  // Trial subtraction one bit wider than the shifted remainder so the top
  // bit of the difference is the borrow.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {2'b00, dvs_mag};
    q_bit   = ~diff[VW+1];
    rem_out = q_bit ? diff[VW:0] : shifted[VW:0];
  end

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed divider (16-bit dividend / 8-bit divisor) with a
// valid/ready handshake on both sides. Magnitudes are divided with
// unsigned restoring division, then signs and flags are applied in FIX.
// Optional macro BOOTH_DIV_RADIX4_EN chains two div_step stages so CALC
// retires two quotient bits per cycle; results are identical.
module booth_seq_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dz,
  output logic          ovf
);

`ifdef BOOTH_DIV_RADIX4_EN
  localparam int ITER = ITER_R4;
`else
  localparam int ITER = ITER_R2;
`endif

  localparam logic [DW-1:0] DVD_MIN = {1'b1, {(DW-1){1'b0}}};

  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [VW:0]      rem_q, rem_d;
  logic [VW-1:0]    dvs_q, dvs_d;
  logic             sign_n_q, sign_n_d;
  logic             sign_d_q, sign_d_d;
  logic [DW-1:0]    quotient_q, quotient_d;
  logic [VW-1:0]    remainder_q, remainder_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [VW:0]      rem_a;
  logic             q_a;

  div_step #(.VW(VW)) u_step_a (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[DW-1]),
    .dvs_mag (dvs_q),
    .rem_out (rem_a),
    .q_bit   (q_a)
  );

`ifdef BOOTH_DIV_RADIX4_EN
  logic [VW:0]      rem_b;
  logic             q_b;

  div_step #(.VW(VW)) u_step_b (
    .rem_in  (rem_a),
    .dvd_bit (dvd_q[DW-2]),
    .dvs_mag (dvs_q),
    .rem_out (rem_b),
    .q_bit   (q_b)
  );
`endif

  // All architectural state; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      sign_n_q    <= 1'b0;
      sign_d_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      sign_n_q    <= sign_n_d;
      sign_d_q    <= sign_d_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state and datapath: latch magnitudes on accept, iterate in CALC
  // (dvd_q shifts out dividend bits and fills with quotient bits), then
  // apply signs and flags in FIX.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    sign_n_d    = sign_n_q;
    sign_d_d    = sign_d_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_n_d = dividend[DW-1];
          sign_d_d = divisor[VW-1];
          dvd_d    = dividend[DW-1] ? -dividend : dividend;
          dvs_d    = divisor[VW-1] ? -divisor : divisor;
          rem_d    = '0;
          cnt_d    = '0;
          dz_d     = 1'b0;
          ovf_d    = 1'b0;
          state_d  = (divisor == '0) ? FIX : CALC;
        end
      end

      CALC: begin
`ifdef BOOTH_DIV_RADIX4_EN
        dvd_d = {dvd_q[DW-3:0], q_a, q_b};
        rem_d = rem_b;
`else
        dvd_d = {dvd_q[DW-2:0], q_a};
        rem_d = rem_a;
`endif
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (dvs_q == '0) begin
          quotient_d  = DW'(DZ_QUOT);
          remainder_d = VW'(DZ_REM);
          dz_d        = 1'b1;
          ovf_d       = 1'b0;
        end else begin
          quotient_d  = (sign_n_q ^ sign_d_q) ? -dvd_q : dvd_q;
          remainder_d = sign_n_q ? -rem_q[VW-1:0] : rem_q[VW-1:0];
          dz_d        = 1'b0;
          // Only -2^(DW-1) / -1 yields a quotient magnitude of 2^(DW-1).
          ovf_d       = sign_n_q & sign_d_q & (dvd_q == DVD_MIN);
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed testbench for booth_seq_divider: hand-computed quotient,
// remainder, flags and latency, plus backpressure and mid-CALC reset.
module tb_booth_seq_divider;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [15:0] dividendIn;
  logic [7:0]  divisorIn;
  logic        outValid;
  logic        outReady;
  logic [15:0] quotientOut;
  logic [7:0]  remainderOut;
  logic        dzOut;
  logic        ovfOut;

  int checkCount;
  int passCount;

`ifdef BOOTH_DIV_RADIX4_EN
  localparam int CALC_LAT = 10;
`else
  localparam int CALC_LAT = 18;
`endif
  localparam int WAIT_LIMIT = 60;

  booth_seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .dividend  (dividendIn),
    .divisor   (divisorIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .quotient  (quotientOut),
    .remainder (remainderOut),
    .dz        (dzOut),
    .ovf       (ovfOut)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Present operands for exactly one accepting edge, then scramble inputs.
  task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs);
    checkOutput("in_ready before accept", 32'(inReady), 32'd1);
    inValid    = 1'b1;
    dividendIn = dvd;
    divisorIn  = dvs;
    @(posedge clk);
    #1;
    inValid    = 1'b0;
    dividendIn = 16'($urandom);
    divisorIn  = 8'($urandom);
  endtask

  // Count cycles after the accept edge until out_valid is seen.
  task automatic waitResult(input int expLat, input string tag);
    int cycles;
    cycles = 0;
    while (cycles < WAIT_LIMIT) begin
      @(negedge clk);
      cycles++;
      if (outValid) break;
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'(expLat));
  endtask

  // Full transaction: accept, wait, check results, optionally stall, consume.
  task automatic runDiv(input string tag, input logic [15:0] dvd,
                        input logic [7:0] dvs, input logic [15:0] expQ,
                        input logic [7:0] expR, input logic expDz,
                        input logic expOvf, input int expLat, input int hold);
    applyStimulus(dvd, dvs);
    waitResult(expLat, tag);
    checkOutput({tag, " quotient"}, 32'(quotientOut), 32'(expQ));
    checkOutput({tag, " remainder"}, 32'(remainderOut), 32'(expR));
    checkOutput({tag, " dz"}, 32'(dzOut), 32'(expDz));
    checkOutput({tag, " ovf"}, 32'(ovfOut), 32'(expOvf));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, " hold out_valid"}, 32'(outValid), 32'd1);
      checkOutput({tag, " hold in_ready"}, 32'(inReady), 32'd0);
      checkOutput({tag, " hold quotient"}, 32'(quotientOut), 32'(expQ));
      checkOutput({tag, " hold remainder"}, 32'(remainderOut), 32'(expR));
    end
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput({tag, " idle in_ready"}, 32'(inReady), 32'd1);
    checkOutput({tag, " idle out_valid"}, 32'(outValid), 32'd0);
    @(negedge clk);
  endtask

  // Directed sequence.
  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    inValid    = 1'b0;
    outReady   = 1'b0;
    dividendIn = '0;
    divisorIn  = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset in_ready", 32'(inReady), 32'd1);
    checkOutput("reset quotient", 32'(quotientOut), 32'd0);
    checkOutput("reset remainder", 32'(remainderOut), 32'd0);
    checkOutput("reset dz", 32'(dzOut), 32'd0);
    checkOutput("reset ovf", 32'(ovfOut), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runDiv("100/7",     16'd100,   8'd7,   16'h000E, 8'h02, 1'b0, 1'b0, CALC_LAT, 0);
    runDiv("-100/7",    16'hFF9C,  8'd7,   16'hFFF2, 8'hFE, 1'b0, 1'b0, CALC_LAT, 0);
    runDiv("100/-7",    16'd100,   8'hF9,  16'hFFF2, 8'h02, 1'b0, 1'b0, CALC_LAT, 0);
    runDiv("-100/-7",   16'hFF9C,  8'hF9,  16'h000E, 8'hFE, 1'b0, 1'b0, CALC_LAT, 0);
    runDiv("min/-1",    16'h8000,  8'hFF,  16'h8000, 8'h00, 1'b0, 1'b1, CALC_LAT, 0);
    runDiv("max/-128",  16'h7FFF,  8'h80,  16'hFF01, 8'h7F, 1'b0, 1'b0, CALC_LAT, 0);
    runDiv("1234/0",    16'd1234,  8'd0,   16'hFFFF, 8'h00, 1'b1, 1'b0, 2, 0);
    runDiv("1000/-3 bp", 16'd1000, 8'hFD,  16'hFEB3, 8'h01, 1'b0, 1'b0, CALC_LAT, 5);
    runDiv("-7/100",    16'hFFF9,  8'd100, 16'h0000, 8'hF9, 1'b0, 1'b0, CALC_LAT, 0);

    applyStimulus(16'd1000, 8'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset out_valid", 32'(outValid), 32'd0);
    checkOutput("midreset in_ready", 32'(inReady), 32'd1);
    checkOutput("midreset quotient", 32'(quotientOut), 32'd0);
    checkOutput("midreset remainder", 32'(remainderOut), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    runDiv("50/5",      16'd50,    8'd5,   16'h000A, 8'h00, 1'b0, 1'b0, CALC_LAT, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/booth_seq_divider.md
# booth_seq_divider

Sequential signed divider that undoes the radix-4 Booth multiplier: a 16-bit two's-complement dividend over an 8-bit two's-complement divisor gives a 16-bit quotient and an 8-bit remainder. It sits beside the multiplier in the arithmetic datapath. It takes operands over a valid/ready handshake, iterates one or two quotient bits per cycle, and holds the result until it is consumed.

## Interface
- DW, 16, dividend and quotient width
- VW, 8, divisor and remainder width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- dividend  input  DW  signed dividend
- divisor  input  VW  signed divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- quotient  output  DW  signed quotient, truncated toward zero
- remainder  output  VW  signed remainder, sign follows dividend
- dz  output  1  divide-by-zero flag
- ovf  output  1  overflow flag (dividend = -2^(DW-1), divisor = -1)

## Operation
- Reset values:
  - out_valid, quotient, remainder, dz and ovf are all 0.
  - State is IDLE, so in_ready = 1.
- Accept when in_valid & in_ready at a clock edge:
  - Latch the sign of each operand.
  - Latch |dividend| as DW-bit unsigned and |divisor| as VW-bit unsigned.
  - Inputs may change freely afterwards.
- States:
  - **IDLE**: on accept, go to FIX if divisor == 0, otherwise go to CALC with the iteration counter cleared.
  - **CALC**: unsigned restoring division on a (VW+1)-bit partial remainder, MSB-first over the dividend magnitude. Radix-2 runs 16 iterations, one quotient bit per cycle. After the last iteration, go to FIX.
  - **FIX**: apply signs and flags (rules below), then go to DONE.
  - **DONE**: out_valid = 1 and outputs are held stable. When out_ready is high, go to IDLE and drop out_valid.
- Sign rules in FIX:
  - Quotient is negated when the operand signs differ.
  - Remainder is negated when the dividend is negative.
  - All arithmetic is modulo 2^DW or 2^VW.
  - -32768 / -1 yields quotient 16'h8000 (natural wrap), remainder 0, ovf = 1.
- Divide by zero: quotient = 16'hFFFF, remainder = 8'h00, dz = 1, ovf = 0.
- dz and ovf are valid only while out_valid is high. They clear on the next accept.
- A divisor of -128 is legal: its magnitude 128 fits in VW unsigned bits.

## Timing
- Accept edge is cycle 0.
- Radix-2: CALC occupies cycles 1–16, FIX cycle 17, out_valid rises in cycle 18.
- Divide by zero: FIX at cycle 1, out_valid in cycle 2.
- in_ready is combinational from state and is low from cycle 1 until the cycle after the handshake on out_valid & out_ready.
- No accept is possible in DONE, even if out_ready is high in the same cycle. Minimum initiation interval is 19 cycles.
- Backpressure: while out_ready is low, state, outputs and flags hold indefinitely.
- rst asserted at any point, including mid-CALC, immediately forces the reset values. The in-flight operation is discarded, with no partial output.

## Configuration
- BOOTH_DIV_RADIX4_EN defined:
  - CALC retires 2 quotient bits per cycle using two chained step stages.
  - 8 iterations; out_valid in cycle 10; initiation interval 11.
  - Results are bit-identical to radix-2.
- BOOTH_DIV_RADIX4_EN undefined: radix-2, 16 iterations, timing as above.

## Structure
- Package div_pkg holds:
  - state enum {IDLE, CALC, FIX, DONE}
  - DW/VW defaults
  - iteration-count constants for radix-2 and radix-4
  - divide-by-zero quotient and remainder constants
- Sub-module div_step: one combinational restoring step. It shifts in one dividend bit, trial-subtracts the divisor magnitude, and outputs the new partial remainder and the quotient bit. It is instantiated once for radix-2 and twice in series for radix-4.

## Test plan
- 100 / 7 → quotient 14, remainder 2, dz = ovf = 0; out_valid exactly 18 cycles after accept (10 with radix-4).
- Signs:
  - -100 / 7 → 16'hFFF2, 8'hFE
  - 100 / -7 → 16'hFFF2, 8'h02
  - -100 / -7 → 16'h000E, 8'hFE
- Boundaries:
  - -32768 / -1 → 16'h8000, 8'h00, ovf = 1
  - 32767 / -128 → 16'hFF01, 8'h7F, ovf = 0
- 1234 / 0 → 16'hFFFF, 8'h00, dz = 1; out_valid in cycle 2.
- Backpressure:
  - Hold out_ready low for 5 cycles in DONE: outputs stable, in_ready low throughout.
  - Raise out_ready: IDLE the next cycle, and a new accept succeeds.
- Reset mid-operation: assert rst at cycle 8 of CALC → outputs 0 and in_ready = 1 immediately; the next operation, 50 / 5, returns 10 r 0.
